// File: rtl/prog_mod_counter_pkg.sv
// Shared types for the programmable modulus counter: count modes and
// one-shot FSM states.
package prog_counter_pkg;

   // Count mode, encoded as the 2-bit mode input.
   typedef enum logic [1:0] {
      MODE_WRAP    = 2'b00,
      MODE_SAT     = 2'b01,
      MODE_ONESHOT = 2'b10,
      MODE_HOLD    = 2'b11
   } mode_t;

   // One-shot sequencer states.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } fsm_t;

endpackage

// File: rtl/prog_mod_counter_if.sv
// Control/status bundle of the programmable modulus counter. The master
// side (timer user) drives the controls; the slave side (counter) returns
// the count and status flags.
interface prog_mod_counter_if #(
   parameter int N      = 8,
   parameter int STEP_W = 4
);
   import prog_counter_pkg::*;

   logic              syn_clr;
   logic              load;
   logic [N-1:0]      d;
   logic              en;
   logic              up;
   logic [STEP_W-1:0] step;
   logic              lim_we;
   logic [N-1:0]      lim_d;
   mode_t             mode;
   logic              start;

   logic [N-1:0]      q;
   logic              max_tick;
   logic              min_tick;
   logic              wrap_tick;
   logic              busy;

   modport master (
      output syn_clr, load, d, en, up, step, lim_we, lim_d, mode, start,
      input  q, max_tick, min_tick, wrap_tick, busy
   );

   modport slave (
      input  syn_clr, load, d, en, up, step, lim_we, lim_d, mode, start,
      output q, max_tick, min_tick, wrap_tick, busy
   );

endinterface

// File: rtl/prog_mod_counter_step_arith.sv
// Step arithmetic for the counter: adds or subtracts a step in N+1 bits,
// flags when the result leaves [0, limit], and resolves the out-of-range
// result either by wrapping to the opposite bound or saturating at the
// bound being approached.
module step_arith #(
   parameter int N      = 8,
   parameter int STEP_W = 4
) (
   input  logic [N-1:0]      i_q,
   input  logic [STEP_W-1:0] i_step,
   input  logic [N-1:0]      i_lim,
   input  logic              i_up,
   input  logic              i_sat,
   output logic [N-1:0]      o_q,
   output logic              o_ovf
);

   logic [N:0] w_q_ext;
   logic [N:0] w_step_ext;
   logic [N:0] w_lim_ext;
   logic [N:0] w_sum;
   logic [N:0] w_diff;

   assign w_q_ext    = {1'b0, i_q};
   assign w_step_ext = (N+1)'(i_step);
   assign w_lim_ext  = {1'b0, i_lim};
   assign w_sum      = w_q_ext + w_step_ext;
   assign w_diff     = w_q_ext - w_step_ext;

   // Pick the in-range result or the wrap/saturation bound for this direction.
   always_comb begin
      // NOTE: outputs are defaulted before any branch so no path can infer a latch.
      o_q   = i_q;
      o_ovf = 1'b0;
      if (i_up) begin
         o_ovf = (w_sum > w_lim_ext);
         o_q   = o_ovf ? (i_sat ? i_lim : '0) : w_sum[N-1:0];
      end else begin
         o_ovf = (w_step_ext > w_q_ext);
         o_q   = o_ovf ? (i_sat ? '0 : i_lim) : w_diff[N-1:0];
      end
   end

endmodule

// File: rtl/prog_mod_counter.sv
// Up/down counter with a programmable limit, variable step and three count
// modes (wrap, saturate, one-shot). Used as timebase, prescaler and interval
// timer. Priority on each edge: syn_clr, then load, then one-shot launch,
// then limit clamp, then counting.
module prog_mod_counter
   import prog_counter_pkg::*;
#(
   parameter int N      = 8,
   parameter int STEP_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   prog_mod_counter_if.slave bus
);

   logic [N-1:0] r_q;
   logic [N-1:0] r_lim;
   fsm_t         r_state;
   logic         r_wrap_tick;
   logic         r_busy;

   logic [N-1:0] w_lim_eff;
   logic [N-1:0] w_load_val;
   logic [N-1:0] w_term;
   logic [N-1:0] w_arith_q;
   logic         w_arith_ovf;
   logic         w_oneshot;
   logic         w_sat;
   logic         w_clamp;
   logic         w_count;
   logic [N-1:0] w_q_nxt;
   fsm_t         w_state_nxt;
   logic         w_tick_nxt;

   // A limit being written this cycle already governs this cycle.
   assign w_lim_eff  = bus.lim_we ? bus.lim_d : r_lim;
   assign w_load_val = (bus.d > w_lim_eff) ? w_lim_eff : bus.d;
   // Terminal count of a one-shot depends on direction.
   assign w_term     = bus.up ? w_lim_eff : '0;
   assign w_oneshot  = (bus.mode == MODE_ONESHOT);
   assign w_sat      = (bus.mode != MODE_WRAP);
   assign w_clamp    = bus.lim_we && (r_q > w_lim_eff);
   // One-shot counts only while running; the other modes count only once
   // a stale one-shot state has been flushed back to IDLE.
   assign w_count    = bus.en && (bus.step != '0) && (bus.mode != MODE_HOLD) &&
                       (w_oneshot ? (r_state == RUN) : (r_state == IDLE));

   step_arith #(
      .N      (N),
      .STEP_W (STEP_W)
   ) u_step_arith (
      .i_q    (r_q),
      .i_step (bus.step),
      .i_lim  (w_lim_eff),
      .i_up   (bus.up),
      .i_sat  (w_sat),
      .o_q    (w_arith_q),
      .o_ovf  (w_arith_ovf)
   );

   // Next count, next FSM state and tick request for the coming edge.
   always_comb begin
      w_q_nxt     = r_q;
      w_state_nxt = r_state;
      w_tick_nxt  = 1'b0;
      if (bus.syn_clr) begin
         w_q_nxt     = '0;
         w_state_nxt = IDLE;
      end else if (bus.load) begin
         // A load aborts a running one-shot unless it lands on the terminal count.
         w_q_nxt     = w_load_val;
         w_state_nxt = IDLE;
         if (w_oneshot && (r_state == RUN) && (w_load_val == w_term)) begin
            w_state_nxt = DONE;
            w_tick_nxt  = 1'b1;
         end
      end else if (w_oneshot && (r_state == IDLE) && bus.start) begin
         w_q_nxt     = bus.up ? '0 : w_lim_eff;
         w_state_nxt = RUN;
      end else begin
         // RUN survives only in one-shot mode; DONE and abandoned runs fall to IDLE.
         w_state_nxt = (w_oneshot && (r_state == RUN)) ? RUN : IDLE;
         if (w_clamp) begin
            w_q_nxt = w_lim_eff;
         end else if (w_count) begin
            w_q_nxt = w_arith_q;
            case (bus.mode)
               MODE_WRAP: w_tick_nxt = w_arith_ovf;
               MODE_SAT:  w_tick_nxt = (w_arith_q != r_q) && (w_arith_q == w_term);
               MODE_ONESHOT: begin
                  if (w_arith_q == w_term) begin
                     w_state_nxt = DONE;
                     w_tick_nxt  = 1'b1;
                  end
               end
               default: w_tick_nxt = 1'b0;
            endcase
         end
      end
   end

   // State registers; reset leaves the full range as the limit.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: registers use non-blocking assignments; the combinational block above uses blocking.
      if (reset) begin
         r_q         <= '0;
         r_lim       <= '1;
         r_state     <= IDLE;
         r_wrap_tick <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_q         <= w_q_nxt;
         r_lim       <= w_lim_eff;
         r_state     <= w_state_nxt;
         r_wrap_tick <= w_tick_nxt;
         r_busy      <= (w_state_nxt == RUN);
      end
   end

   assign bus.q         = r_q;
   assign bus.max_tick  = (r_q == r_lim);
   assign bus.min_tick  = (r_q == '0);
   assign bus.wrap_tick = r_wrap_tick;
   assign bus.busy      = r_busy;

endmodule

// File: tb/tb_prog_mod_counter.sv
// Bench for prog_mod_counter: directed scenarios plus randomized traffic,
// all checked by a scoreboard fed from a behavioural model.
module tb_prog_mod_counter;
   import prog_counter_pkg::*;

   localparam int N      = 8;
   localparam int STEP_W = 4;

   logic clk;
   logic reset;

   prog_mod_counter_if #(.N(N), .STEP_W(STEP_W)) bus ();

   prog_mod_counter #(.N(N), .STEP_W(STEP_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int q;
      bit tick;
      bit busy;
      bit maxt;
      bit mint;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Behavioural model state: plain integers and flags.
   int m_q;
   int m_lim;
   bit m_running;
   bit m_done;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q       = 0;
      m_lim     = (1 << N) - 1;
      m_running = 1'b0;
      m_done    = 1'b0;
   endtask

   // Compute the result of the coming edge from the current inputs and push it.
   task automatic model_step();
      exp_t e;
      int   lim_e, term, q_n, raw;
      bit   run_n, done_n, tick, counting;
      lim_e  = bus.lim_we ? int'(bus.lim_d) : m_lim;
      term   = bus.up ? lim_e : 0;
      q_n    = m_q;
      run_n  = 1'b0;
      done_n = 1'b0;
      tick   = 1'b0;
      if (bus.syn_clr) begin
         q_n = 0;
      end else if (bus.load) begin
         q_n = (int'(bus.d) > lim_e) ? lim_e : int'(bus.d);
         if (bus.mode == MODE_ONESHOT && m_running && q_n == term) begin
            done_n = 1'b1;
            tick   = 1'b1;
         end
      end else if (bus.mode == MODE_ONESHOT && !m_running && !m_done && bus.start) begin
         q_n   = bus.up ? 0 : lim_e;
         run_n = 1'b1;
      end else begin
         run_n    = (bus.mode == MODE_ONESHOT) && m_running;
         counting = bus.en && (bus.step != 0) && (bus.mode != MODE_HOLD) &&
                    ((bus.mode == MODE_ONESHOT) ? m_running : (!m_running && !m_done));
         if (bus.lim_we && m_q > lim_e) begin
            q_n = lim_e;
         end else if (counting) begin
            raw = bus.up ? m_q + int'(bus.step) : m_q - int'(bus.step);
            if (bus.mode == MODE_WRAP) begin
               if (raw > lim_e || raw < 0) begin
                  q_n  = bus.up ? 0 : lim_e;
                  tick = 1'b1;
               end else begin
                  q_n = raw;
               end
            end else begin
               q_n = (raw > lim_e) ? lim_e : ((raw < 0) ? 0 : raw);
               if (bus.mode == MODE_SAT) begin
                  tick = (q_n != m_q) && (q_n == term);
               end else if (q_n == term) begin
                  run_n  = 1'b0;
                  done_n = 1'b1;
                  tick   = 1'b1;
               end
            end
         end
      end
      m_q       = q_n;
      m_lim     = lim_e;
      m_running = run_n;
      m_done    = done_n;
      e.q    = q_n;
      e.tick = tick;
      e.busy = run_n;
      e.maxt = (q_n == lim_e);
      e.mint = (q_n == 0);
      sb.push_back(e);
   endtask

   // Called at a falling edge with inputs set; returns at the next falling edge.
   task automatic step_cycle();
      model_step();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.syn_clr = 1'b0;
      bus.load    = 1'b0;
      bus.d       = '0;
      bus.en      = 1'b0;
      bus.up      = 1'b1;
      bus.step    = '0;
      bus.lim_we  = 1'b0;
      bus.lim_d   = '0;
      bus.mode    = MODE_WRAP;
      bus.start   = 1'b0;
   endtask

   // Monitor: after every rising edge, compare the DUT against the oldest expectation.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check("sb_q",         32'(bus.q),     32'(e.q));
         check("sb_wrap_tick", 32'(bus.wrap_tick), 32'(e.tick));
         check("sb_busy",      32'(bus.busy),  32'(e.busy));
         check("sb_max_tick",  32'(bus.max_tick), 32'(e.maxt));
         check("sb_min_tick",  32'(bus.min_tick), 32'(e.mint));
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int ticks;
      idle_inputs();
      reset = 1'b1;
      model_reset();
      #1;
      check("rst_q",        32'(bus.q), 0);
      check("rst_busy",     32'(bus.busy), 0);
      check("rst_wrap",     32'(bus.wrap_tick), 0);
      check("rst_min_tick", 32'(bus.min_tick), 1);
      check("rst_max_tick", 32'(bus.max_tick), 0);
      @(negedge clk);
      reset = 1'b0;

      // WRAP, limit 9, step 1 up: 0..9 then 0.
      bus.lim_we = 1'b1; bus.lim_d = 8'd9;
      step_cycle();
      bus.lim_we = 1'b0; bus.en = 1'b1; bus.step = 4'd1; bus.up = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         step_cycle();
         check("wrap_up_seq", 32'(bus.q), 32'(i));
      end
      check("wrap_up_max_tick", 32'(bus.max_tick), 1);
      step_cycle();
      check("wrap_up_q0",   32'(bus.q), 0);
      check("wrap_up_tick", 32'(bus.wrap_tick), 1);
      step_cycle();
      check("wrap_up_q1",     32'(bus.q), 1);
      check("wrap_up_tick_off", 32'(bus.wrap_tick), 0);

      // WRAP down, step 4 from 2: 9 (tick), 5, 1, 9 (tick).
      bus.en = 1'b0; bus.load = 1'b1; bus.d = 8'd2;
      step_cycle();
      bus.load = 1'b0; bus.en = 1'b1; bus.step = 4'd4; bus.up = 1'b0;
      step_cycle();
      check("wrap_dn_q9",   32'(bus.q), 9);
      check("wrap_dn_tick", 32'(bus.wrap_tick), 1);
      step_cycle();
      check("wrap_dn_q5", 32'(bus.q), 5);
      step_cycle();
      check("wrap_dn_q1", 32'(bus.q), 1);
      step_cycle();
      check("wrap_dn_q9b",   32'(bus.q), 9);
      check("wrap_dn_tick2", 32'(bus.wrap_tick), 1);

      // SAT, limit 200, step 15 up from 190: settle at 200 with one tick, then down to 185.
      bus.en = 1'b0; bus.mode = MODE_SAT;
      bus.lim_we = 1'b1; bus.lim_d = 8'd200; bus.load = 1'b1; bus.d = 8'd190;
      step_cycle();
      check("sat_load", 32'(bus.q), 190);
      bus.lim_we = 1'b0; bus.load = 1'b0; bus.en = 1'b1; bus.step = 4'd15; bus.up = 1'b1;
      ticks = 0;
      for (int i = 0; i < 4; i++) begin
         step_cycle();
         ticks += int'(bus.wrap_tick);
      end
      check("sat_q200",     32'(bus.q), 200);
      check("sat_one_tick", 32'(ticks), 1);
      bus.up = 1'b0;
      step_cycle();
      check("sat_down_q185", 32'(bus.q), 185);

      // ONESHOT, limit 5, up.
      bus.en = 1'b0; bus.syn_clr = 1'b1; bus.lim_we = 1'b1; bus.lim_d = 8'd5; bus.mode = MODE_ONESHOT;
      step_cycle();
      bus.syn_clr = 1'b0; bus.lim_we = 1'b0; bus.en = 1'b1; bus.step = 4'd1; bus.up = 1'b1;
      bus.start = 1'b1;
      step_cycle();
      check("os_start_q",    32'(bus.q), 0);
      check("os_start_busy", 32'(bus.busy), 1);
      bus.start = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         step_cycle();
         check("os_run_q",    32'(bus.q), 32'(i));
         check("os_run_busy", 32'(bus.busy), (i < 5) ? 32'd1 : 32'd0);
         check("os_run_tick", 32'(bus.wrap_tick), (i == 5) ? 32'd1 : 32'd0);
      end
      step_cycle();
      check("os_after_q",    32'(bus.q), 5);
      check("os_after_tick", 32'(bus.wrap_tick), 0);
      check("os_after_busy", 32'(bus.busy), 0);
      bus.start = 1'b1;
      step_cycle();
      check("os_restart_q",    32'(bus.q), 0);
      check("os_restart_busy", 32'(bus.busy), 1);
      bus.start = 1'b0;

      // Simultaneous events: clamp on limit write, syn_clr over load, load clamped to limit.
      bus.en = 1'b0; bus.mode = MODE_WRAP;
      bus.lim_we = 1'b1; bus.lim_d = 8'd255; bus.load = 1'b1; bus.d = 8'd100;
      step_cycle();
      check("sim_load100", 32'(bus.q), 100);
      bus.load = 1'b0; bus.lim_d = 8'd50;
      step_cycle();
      check("sim_clamp50", 32'(bus.q), 50);
      bus.lim_we = 1'b0; bus.load = 1'b1; bus.d = 8'd80; bus.syn_clr = 1'b1;
      step_cycle();
      check("sim_clr_wins", 32'(bus.q), 0);
      bus.syn_clr = 1'b0;
      step_cycle();
      check("sim_load_clamp", 32'(bus.q), 50);

      // Asynchronous reset between edges while counting.
      bus.load = 1'b0; bus.en = 1'b1; bus.step = 4'd3; bus.up = 1'b1;
      for (int i = 0; i < 3; i++) step_cycle();
      idle_inputs();
      #2 reset = 1'b1;
      #1;
      check("arst_q",     32'(bus.q), 0);
      check("arst_busy",  32'(bus.busy), 0);
      check("arst_max",   32'(bus.max_tick), 0);
      check("arst_min",   32'(bus.min_tick), 1);
      #1 reset = 1'b0;
      model_reset();
      step_cycle();
      // Limit must be back at 255: 17 steps of 15 reach 255, the next wraps.
      bus.en = 1'b1; bus.step = 4'd15; bus.up = 1'b1;
      for (int i = 0; i < 17; i++) step_cycle();
      check("arst_lim_q255", 32'(bus.q), 255);
      check("arst_lim_max",  32'(bus.max_tick), 1);
      step_cycle();
      check("arst_lim_wrap", 32'(bus.q), 0);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         bus.syn_clr = ($urandom_range(0, 99) < 2);
         bus.load    = ($urandom_range(0, 99) < 5);
         bus.d       = N'($urandom);
         bus.lim_we  = ($urandom_range(0, 99) < 4);
         bus.lim_d   = ($urandom_range(0, 1) != 0) ? N'($urandom_range(0, 20)) : N'($urandom);
         bus.start   = ($urandom_range(0, 99) < 15);
         bus.en      = ($urandom_range(0, 99) < 85);
         if ($urandom_range(0, 99) < 10) bus.up = ~bus.up;
         bus.step    = ($urandom_range(0, 1) != 0) ? STEP_W'($urandom_range(0, 3)) : STEP_W'($urandom);
         if ($urandom_range(0, 99) < 4) bus.mode = mode_t'($urandom_range(0, 3));
         step_cycle();
      end

      idle_inputs();
      @(negedge clk);
      check("sb_drained", 32'(sb.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
